// File: rtl/fma_pkg.sv
// fma_pkg: shared float_sp layout, FMA/dispatcher state encodings and result flag bit positions.
package fma_pkg;
  localparam int EXPBITS = 8;
  localparam int MANBITS = 23;
  typedef struct packed {
    logic sign;
    logic [EXPBITS-1:0] exp;
    logic [MANBITS-1:0] man;
  } float_sp;
  typedef enum logic [1:0] {FMA_READY, FMA_BUSY, FMA_DONE} fma_state_e;
  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT, DELIVER} fma_disp_state_e;
  localparam int FLAG_UNF = 0;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_TMO = 2;
endpackage

// File: rtl/fma_operand_fifo.sv
// fma_operand_fifo: DEPTH-entry synchronous FIFO holding operand pairs; caller guarantees legal push/pop.
module fma_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fma_operand_dispatch.sv
// fma_operand_dispatch: buffers operand pairs and drives the FMA req/hold/gap protocol, returning results.
// Optional FMA_ZERO_BYPASS_EN: pairs with a zero operand are answered locally without an FMA request.
module fma_operand_dispatch
  import fma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REQ_GAP = 10,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid_in,
  output logic        push_ready_out,
  input  logic [31:0] push_a_in,
  input  logic [31:0] push_b_in,
  output logic [31:0] float_0_out,
  output logic [31:0] float_1_out,
  output logic        float_0_req_out,
  output logic        float_1_req_out,
  input  logic        fma_busy_in,
  input  logic        ready_answer_in,
  input  logic [31:0] answer_in,
  input  logic        overflow_in,
  input  logic        underflow_in,
  output logic        result_valid_out,
  input  logic        result_ready_in,
  output logic [31:0] result_out,
  output logic [2:0]  result_flags_out
);
  localparam int GW = $clog2(REQ_GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  fma_disp_state_e state, state_nx;
  logic [GW-1:0] gap;
  logic [TW-1:0] tcnt;
  logic hold_cnt, empty, full, pop, zero_pair, tmo;
  logic [63:0] head;
  float_sp op_a, op_b;
  fma_operand_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push_valid_in & push_ready_out),
    .pop(pop),
    .din({push_a_in, push_b_in}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign op_a = head[63:32];
  assign op_b = head[31:0];
`ifdef FMA_ZERO_BYPASS_EN
  assign zero_pair = ({op_a.exp, op_a.man} == '0) || ({op_b.exp, op_b.man} == '0);
`else
  assign zero_pair = 1'b0;
`endif
  assign pop = state == IDLE && !empty && gap == '0 && !fma_busy_in;
  assign push_ready_out = !full || pop;
  assign tmo = tcnt == TW'(TIMEOUT - 1);
  assign float_0_req_out = state == ISSUE;
  assign float_1_req_out = state == ISSUE;
  assign result_valid_out = state == DELIVER;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = pop ? (zero_pair ? DELIVER : ISSUE) : IDLE;
      ISSUE:   state_nx = HOLD;
      HOLD:    state_nx = hold_cnt ? WAIT : HOLD;
      WAIT:    state_nx = (ready_answer_in || tmo) ? DELIVER : WAIT;
      DELIVER: state_nx = result_ready_in ? IDLE : DELIVER;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gap <= '0;
      tcnt <= '0;
      hold_cnt <= 1'b0;
      float_0_out <= '0;
      float_1_out <= '0;
      result_out <= '0;
      result_flags_out <= '0;
    end else begin
      state <= state_nx;
      gap <= (state == HOLD && hold_cnt) ? GW'(REQ_GAP) : (gap != '0 ? gap - GW'(1) : gap);
      hold_cnt <= state == HOLD ? !hold_cnt : 1'b0;
      tcnt <= state == WAIT ? tcnt + TW'(1) : '0;
      if (pop && !zero_pair) begin
        float_0_out <= op_a;
        float_1_out <= op_b;
      end
      if (pop && zero_pair) begin
        result_out <= {op_a.sign ^ op_b.sign, 31'b0};
        result_flags_out <= '0;
      end
      // The first ready_answer wins over a timeout expiring in the same cycle.
      if (state == WAIT && ready_answer_in) begin
        result_out <= answer_in;
        result_flags_out <= '0;
        result_flags_out[FLAG_OVF] <= overflow_in;
        result_flags_out[FLAG_UNF] <= underflow_in;
      end else if (state == WAIT && tmo) begin
        result_out <= '0;
        result_flags_out <= '0;
        result_flags_out[FLAG_TMO] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fma_operand_dispatch.sv
// tb_fma_operand_dispatch: directed vectors, FMA behavioural model and result scoreboard.
module tb_fma_operand_dispatch;
  logic clk = 0, rst = 1;
  logic push_valid_in = 0, push_ready_out;
  logic [31:0] push_a_in = 0, push_b_in = 0;
  logic [31:0] float_0_out, float_1_out;
  logic float_0_req_out, float_1_req_out;
  logic fma_busy_in = 0, ready_answer_in = 0;
  logic [31:0] answer_in = 0;
  logic overflow_in = 0, underflow_in = 0;
  logic result_valid_out, result_ready_in = 1;
  logic [31:0] result_out;
  logic [2:0] result_flags_out;
  always #5 clk = ~clk;

  fma_operand_dispatch dut (
    .clk(clk), .rst(rst),
    .push_valid_in(push_valid_in), .push_ready_out(push_ready_out),
    .push_a_in(push_a_in), .push_b_in(push_b_in),
    .float_0_out(float_0_out), .float_1_out(float_1_out),
    .float_0_req_out(float_0_req_out), .float_1_req_out(float_1_req_out),
    .fma_busy_in(fma_busy_in), .ready_answer_in(ready_answer_in),
    .answer_in(answer_in), .overflow_in(overflow_in), .underflow_in(underflow_in),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .result_out(result_out), .result_flags_out(result_flags_out)
  );

`ifdef FMA_ZERO_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif

  int checks = 0, errors = 0, cyc = 0, reqs = 0;
  logic [63:0] op_q[$];
  logic [33:0] ans_q[$];
  logic [34:0] exp_q[$];
  int model_lat = 4;
  bit model_mute = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FMA model: answers model_lat cycles after a request, checks operands and request shape.
  bit pend = 0, prev_req = 0;
  int pend_cnt = 0, hold_left = 0, last_req = -1000;
  logic [33:0] pend_ans = '0;
  logic [63:0] held = '0;
  always @(negedge clk) begin
    ready_answer_in = 0;
    if (pend) begin
      if (pend_cnt == 0) begin
        {answer_in, overflow_in, underflow_in} = pend_ans;
        ready_answer_in = 1;
        pend = 0;
      end else pend_cnt--;
    end
    if (hold_left > 0) begin
      check("hold_operands", {float_0_out, float_1_out}, held);
      hold_left--;
    end
    if (float_0_req_out) begin
      reqs++;
      check("req_pair", 64'(float_1_req_out), 64'(1));
      check("req_single_cycle", 64'(prev_req), 64'(0));
      check("req_spacing_ge13", 64'(cyc - last_req >= 13), 64'(1));
      last_req = cyc;
      held = {float_0_out, float_1_out};
      hold_left = 2;
      check("req_was_expected", 64'(op_q.size() != 0), 64'(1));
      if (op_q.size() != 0) check("req_operands", {float_0_out, float_1_out}, op_q.pop_front());
      if (!model_mute && ans_q.size() != 0) begin
        pend_ans = ans_q.pop_front();
        pend = 1;
        pend_cnt = model_lat - 1;
      end
    end
    prev_req = float_0_req_out;
  end

  // Result monitor: pops the scoreboard on every accepted result.
  bit stall = 0;
  logic [34:0] stall_val = '0;
  always @(negedge clk) begin
    if (!rst) stall = 0;
    else begin
      if (stall && result_valid_out)
        check("stall_stable", 64'({result_out, result_flags_out}), 64'(stall_val));
      if (result_valid_out && result_ready_in) begin
        if (exp_q.size() == 0) check("result_expected", 64'(exp_q.size()), 64'(1));
        else check("result", 64'({result_out, result_flags_out}), 64'(exp_q.pop_front()));
      end
      stall = result_valid_out && !result_ready_in;
      stall_val = {result_out, result_flags_out};
    end
  end

  task automatic push_raw(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    push_a_in = a;
    push_b_in = b;
    push_valid_in = 1;
    while (!push_ready_out && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_accept_bound", 64'(n < 500), 64'(1));
    @(posedge clk); #1;
    push_valid_in = 0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ans,
                      input logic ov, input logic un, input logic [31:0] res,
                      input logic [2:0] fl, input bit issue);
    if (issue) begin
      op_q.push_back({a, b});
      if (!model_mute) ans_q.push_back({ans, ov, un});
    end
    exp_q.push_back({res, fl});
    push_raw(a, b);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || result_valid_out) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_bound", 64'(n < 2000), 64'(1));
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int c);
    int n = 0;
    @(negedge clk);
    while (!float_0_req_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_seen_bound", 64'(n < 200), 64'(1));
    c = cyc;
  endtask

  initial begin
    int c0, r0, n;
    #1 rst = 0;
    #1;
    check("rst_push_ready", 64'(push_ready_out), 64'(1));
    check("rst_valid", 64'(result_valid_out), 64'(0));
    check("rst_req", 64'({float_0_req_out, float_1_req_out}), 64'(0));
    check("rst_operands", {float_0_out, float_1_out}, 64'(0));
    check("rst_result", 64'({result_out, result_flags_out}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;

    send(32'h3f800000, 32'h3f800000, 32'h3f800000, 0, 0, 32'h3f800000, 3'b000, 1);
    wait_drain();

    send(32'h41700000, 32'hc1a00000, 32'hc3960000, 0, 0, 32'hc3960000, 3'b000, 1);
    send(32'hc1d00000, 32'h41f80000, 32'hc4498000, 0, 0, 32'hc4498000, 3'b000, 1);
    wait_drain();

    fma_busy_in = 1;
    result_ready_in = 0;
    send(32'h3f800000, 32'h40000000, 32'h40000000, 0, 0, 32'h40000000, 3'b000, 1);
    send(32'h40000000, 32'h40000000, 32'h40800000, 0, 0, 32'h40800000, 3'b000, 1);
    send(32'h40400000, 32'h40000000, 32'h40c00000, 0, 0, 32'h40c00000, 3'b000, 1);
    send(32'h7f000000, 32'h7f000000, 32'h7f800000, 1, 0, 32'h7f800000, 3'b010, 1);
    check("full_push_ready", 64'(push_ready_out), 64'(0));
    op_q.push_back({32'h00800000, 32'h00800000});
    ans_q.push_back({32'h00000000, 1'b0, 1'b1});
    exp_q.push_back({32'h00000000, 3'b001});
    push_a_in = 32'h00800000;
    push_b_in = 32'h00800000;
    push_valid_in = 1;
    fma_busy_in = 0;
    #1;
    check("full_push_pop_ready", 64'(push_ready_out), 64'(1));
    @(posedge clk); #1;
    push_valid_in = 0;
    check("full_after_push_pop", 64'(push_ready_out), 64'(0));
    repeat (30) @(posedge clk);
    #1;
    result_ready_in = 1;
    wait_drain();

    model_mute = 1;
    send(32'h40000000, 32'h40000000, 32'h0, 0, 0, 32'h00000000, 3'b100, 1);
    wait_req(c0);
    n = 0;
    while (!result_valid_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 64'(cyc - c0), 64'(19));
    wait_drain();
    model_mute = 0;

    r0 = reqs;
    send(32'h00000000, 32'hc1a00000, 32'h80000000, 0, 0, 32'h80000000, 3'b000, !BYP);
    wait_drain();
    check("zero_pair_req_count", 64'(reqs - r0), BYP ? 64'(0) : 64'(1));

    model_lat = 8;
    op_q.push_back({32'h40000000, 32'h40400000});
    ans_q.push_back({32'h40c00000, 1'b0, 1'b0});
    push_raw(32'h40000000, 32'h40400000);
    push_raw(32'h3f800000, 32'h3f800000);
    wait_req(c0);
    repeat (4) @(negedge clk);
    rst = 0;
    #1;
    check("midrst_valid", 64'(result_valid_out), 64'(0));
    check("midrst_req", 64'(float_0_req_out), 64'(0));
    check("midrst_operands", {float_0_out, float_1_out}, 64'(0));
    check("midrst_push_ready", 64'(push_ready_out), 64'(1));
    check("midrst_result", 64'({result_out, result_flags_out}), 64'(0));
    r0 = reqs;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (40) @(negedge clk);
    check("late_answer_no_valid", 64'(result_valid_out), 64'(0));
    check("fifo_empty_no_req", 64'(reqs - r0), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("op_queue_empty", 64'(op_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
